i2c_calc_core: RTL and testbench

Calculator engine directly downstream of the i2c slave peripheral. It consumes received write bytes (opcode, operand A, operand B), computes a 16-bit result, and serves result and status bytes back to the slave on read requests. Division and modulo use a serial sub-unit, so the block has a busy phase. The result low byte also drives the chip's dedicated outputs for visual debug.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/calc_div8.sv | 63 ++++++
 rtl/i2c_calc_core.sv | 169 ++++++++++++++++
 tb/tb_i2c_calc_core.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the i2c calculator core: opcodes, FSM states,
// status byte layout and read pointer type.
package calc_pkg;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_MUL = 8'h02;
    localparam logic [7:0] OP_DIV = 8'h03;
    localparam logic [7:0] OP_MOD = 8'h04;
    localparam logic [7:0] OP_AND = 8'h05;
    localparam logic [7:0] OP_OR  = 8'h06;
    localparam logic [7:0] OP_XOR = 8'h07;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_DIV,
        S_DONE
    } state_t;

    localparam int unsigned ST_BUSY    = 7;
    localparam int unsigned ST_ERR     = 6;
    localparam int unsigned ST_OVERRUN = 5;
    localparam int unsigned ST_DONE    = 0;

    localparam int unsigned PTR_W = 2;
    typedef logic [PTR_W-1:0] rd_ptr_t;
    localparam rd_ptr_t PTR_LAST = 2'd2;

endpackage

// File: rtl/calc_div8.sv
// Serial restoring 8-bit divider: one quotient bit per cycle, eight cycles
// from start to done.
module calc_div8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       busy,
    output logic       done
);

    logic [7:0] rem_q, quo_q, dvs_q;
    logic [3:0] cnt_q;
    logic [7:0] rem_in, quo_in, dvs_in, rem_nx, quo_nx;
    logic [8:0] shifted;

    // The first step is taken on the start edge itself, so done rises
    // after the eighth step without an extra load cycle.
    always_comb begin
        rem_in  = start ? '0 : rem_q;
        quo_in  = start ? dividend : quo_q;
        dvs_in  = start ? divisor : dvs_q;
        shifted = {rem_in, quo_in[7]};
        if (shifted >= {1'b0, dvs_in}) begin
            rem_nx = 8'(shifted - {1'b0, dvs_in});
            quo_nx = {quo_in[6:0], 1'b1};
        end else begin
            rem_nx = shifted[7:0];
            quo_nx = {quo_in[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (start) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            dvs_q <= divisor;
            cnt_q <= 4'd7;
            done  <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - 4'd1;
            done  <= (cnt_q == 4'd1);
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign busy      = (cnt_q != '0);

endmodule

// File: rtl/i2c_calc_core.sv
// Calculator engine behind the i2c slave: collects opcode/A/B write bytes,
// computes a 16-bit result and serves result/status bytes on reads.
module i2c_calc_core
    import calc_pkg::*;
#(
    parameter bit DIV_EN = 1'b1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       wr_start,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    input  logic       wr_stop,
    input  logic       rd_start,
    input  logic       rd_req,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [7:0] result_lo
);

    state_t      state_q, state_d;
    logic [7:0]  op_q, a_q, b_q;
    logic [15:0] result_q, exec_res;
    logic        err_q, overrun_q, done_q, hold_q;
    logic        exec_err, exec_div;
    logic        op_load, a_load, b_load;
    rd_ptr_t     ptr_q, ptr_eff;
    logic [7:0]  status, rd_byte;
    logic [7:0]  div_quo, div_rem;
    logic        div_start, div_busy, div_done;

    assign busy      = (state_q == S_EXEC) || (state_q == S_DIV);
    assign result_lo = result_q[7:0];
    assign div_start = (state_q == S_EXEC) && exec_div;

    calc_div8 u_div (
        .clk       (clk),
        .rst       (RST),
        .start     (div_start),
        .dividend  (a_q),
        .divisor   (b_q),
        .quotient  (div_quo),
        .remainder (div_rem),
        .busy      (div_busy),
        .done      (div_done)
    );

    always_comb begin
        exec_res = '0;
        exec_err = 1'b0;
        exec_div = 1'b0;
        case (op_q)
            OP_ADD: exec_res = 16'(a_q) + 16'(b_q);
            OP_SUB: exec_res = 16'(a_q) - 16'(b_q);
            OP_MUL: exec_res = 16'(a_q) * 16'(b_q);
            OP_AND: exec_res = {8'h00, a_q & b_q};
            OP_OR:  exec_res = {8'h00, a_q | b_q};
            OP_XOR: exec_res = {8'h00, a_q ^ b_q};
            OP_DIV, OP_MOD: begin
                if (!DIV_EN) begin
                    exec_err = 1'b1;
                end else if (b_q == '0) begin
                    exec_err = 1'b1;
                    exec_res = '1;
                end else begin
                    exec_div = 1'b1;
                end
            end
            default: exec_err = 1'b1;
        endcase
    end

    // hold_q swallows any bytes after the third until STOP or a new START.
    always_comb begin
        state_d = state_q;
        op_load = 1'b0;
        a_load  = 1'b0;
        b_load  = 1'b0;
        case (state_q)
            S_IDLE, S_GET_A, S_GET_B: begin
                if (wr_start) begin
                    state_d = S_IDLE;
                    if (wr_valid) begin
                        state_d = S_GET_A;
                        op_load = 1'b1;
                    end
                end else if (wr_stop && state_q != S_IDLE) begin
                    state_d = S_IDLE;
                end else if (wr_valid) begin
                    if (state_q == S_IDLE && !hold_q) begin
                        state_d = S_GET_A;
                        op_load = 1'b1;
                    end else if (state_q == S_GET_A) begin
                        state_d = S_GET_B;
                        a_load  = 1'b1;
                    end else if (state_q == S_GET_B) begin
                        state_d = S_EXEC;
                        b_load  = 1'b1;
                    end
                end
            end
            S_EXEC:  state_d = exec_div ? S_DIV : S_DONE;
            S_DIV:   if (div_done && !div_busy) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        status             = '0;
        status[ST_BUSY]    = busy;
        status[ST_ERR]     = err_q;
        status[ST_OVERRUN] = overrun_q;
        status[ST_DONE]    = done_q;
        ptr_eff = rd_start ? '0 : ptr_q;
        case (ptr_eff)
            2'd0:    rd_byte = result_q[15:8];
            2'd1:    rd_byte = result_q[7:0];
            default: rd_byte = status;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
            hold_q    <= 1'b0;
            ptr_q     <= '0;
            rd_data   <= '0;
        end else begin
            state_q <= state_d;
            if (op_load) op_q <= wr_data;
            if (a_load)  a_q  <= wr_data;
            if (b_load)  b_q  <= wr_data;

            if (b_load)                 hold_q <= 1'b1;
            else if (wr_start || wr_stop) hold_q <= 1'b0;

            if (wr_start)         overrun_q <= 1'b0;
            if (wr_valid && busy) overrun_q <= 1'b1;

            if (b_load) done_q <= 1'b0;
            if (state_q == S_EXEC && !exec_div) begin
                result_q <= exec_res;
                err_q    <= exec_err;
                done_q   <= 1'b1;
            end
            if (state_q == S_DIV && state_d == S_DONE) begin
                result_q <= (op_q == OP_MOD) ? {8'h00, div_rem} : {8'h00, div_quo};
                err_q    <= 1'b0;
                done_q   <= 1'b1;
            end

            if (rd_req) begin
                rd_data <= rd_byte;
                ptr_q   <= (ptr_eff == PTR_LAST) ? '0 : ptr_eff + 2'd1;
            end else if (rd_start) begin
                ptr_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_calc_core.sv
// Scoreboard bench for i2c_calc_core: expected read bytes are queued at
// stimulus time and checked by an independent monitor.
module tb_i2c_calc_core;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       wr_start = 1'b0, wr_valid = 1'b0, wr_stop = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_start = 1'b0, rd_req = 1'b0;
    logic [7:0] rd_data, result_lo, nd_rd_data, nd_result_lo;
    logic       busy, nd_busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];
    logic rd_seen = 1'b0;

    always #5 clk = ~clk;

    i2c_calc_core #(.DIV_EN(1'b1)) u_dut (
        .clk(clk), .RST(RST), .wr_start(wr_start), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_stop(wr_stop), .rd_start(rd_start),
        .rd_req(rd_req), .rd_data(rd_data), .busy(busy), .result_lo(result_lo)
    );

    i2c_calc_core #(.DIV_EN(1'b0)) u_nodiv (
        .clk(clk), .RST(RST), .wr_start(wr_start), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_stop(wr_stop), .rd_start(rd_start),
        .rd_req(rd_req), .rd_data(nd_rd_data), .busy(nd_busy), .result_lo(nd_result_lo)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_seen <= rd_req;

    initial begin : monitor
        logic [7:0] e;
        int idx;
        idx = 0;
        forever begin
            @(negedge clk);
            if (rd_seen) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got %0h want none", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rd_byte%0d", idx), {8'h00, rd_data}, {8'h00, e});
                end
                idx++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        wr_start = 1'b1;
        cyc();
        wr_start = 1'b0;
    endtask

    task automatic pulse_stop();
        wr_stop = 1'b1;
        cyc();
        wr_stop = 1'b0;
    endtask

    task automatic pulse_rd_start();
        rd_start = 1'b1;
        cyc();
        rd_start = 1'b0;
    endtask

    task automatic rd(input logic [7:0] e);
        exp_q.push_back(e);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
    endtask

    task automatic rd3(input logic [7:0] h, input logic [7:0] l, input logic [7:0] s);
        pulse_rd_start();
        rd(h);
        rd(l);
        rd(s);
    endtask

    task automatic frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        pulse_start();
        send(op);
        send(a);
        send(b);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin
            cyc();
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got busy=1 want busy=0", name);
        end
    endtask

    initial begin
        int n, nd;
        repeat (3) cyc();
        check("reset_rd_data", {8'h00, rd_data}, 16'h0000);
        check("reset_busy", {15'h0, busy}, 16'h0000);
        check("reset_result_lo", {8'h00, result_lo}, 16'h0000);
        RST = 1'b0;
        cyc();
        rd3(8'h00, 8'h00, 8'h00);

        // ADD 0xFF + 0x01 = 0x0100
        frame(8'h00, 8'hFF, 8'h01);
        wait_idle("add");
        check("add_result_lo", {8'h00, result_lo}, 16'h0000);
        pulse_stop();
        rd3(8'h01, 8'h00, 8'h01);

        // SUB 3 - 5 = 0xFFFE, with result timing check
        frame(8'h01, 8'h03, 8'h05);
        check("sub_exec_busy", {15'h0, busy}, 16'h0001);
        check("sub_lo_before", {8'h00, result_lo}, 16'h0000);
        cyc();
        check("sub_lo_after", {8'h00, result_lo}, 16'h00FE);
        check("sub_done_busy", {15'h0, busy}, 16'h0000);
        pulse_stop();
        rd3(8'hFF, 8'hFE, 8'h01);

        // MUL 0xFF * 0xFF = 0xFE01
        frame(8'h02, 8'hFF, 8'hFF);
        wait_idle("mul");
        pulse_stop();
        rd3(8'hFE, 8'h01, 8'h01);

        // XOR 0xA5 ^ 0x0F = 0x00AA
        frame(8'h07, 8'hA5, 8'h0F);
        wait_idle("xor");
        pulse_stop();
        rd3(8'h00, 8'hAA, 8'h01);

        // DIV 200 / 7 = 28; busy for EXEC + 8 DIV cycles; DIV_EN=0 copy errs
        frame(8'h03, 8'hC8, 8'h07);
        n = 0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) n++;
            if (nd_busy) nd++;
            cyc();
        end
        check("div_busy_cycles", 16'(n), 16'd9);
        check("nodiv_busy_cycles", 16'(nd), 16'd1);
        check("nodiv_result_lo", {8'h00, nd_result_lo}, 16'h0000);
        pulse_stop();
        pulse_rd_start();
        rd(8'h00);
        check("nodiv_rd_hi", {8'h00, nd_rd_data}, 16'h0000);
        rd(8'h1C);
        check("nodiv_rd_lo", {8'h00, nd_rd_data}, 16'h0000);
        rd(8'h01);
        check("nodiv_rd_status", {8'h00, nd_rd_data}, 16'h0041);

        // Modulo 200 % 7 = 4, with reads while dividing returning stale data
        frame(8'h04, 8'hC8, 8'h07);
        rd3(8'h00, 8'h1C, 8'h80);
        wait_idle("mod");
        pulse_stop();
        rd3(8'h00, 8'h04, 8'h01);

        // DIV by zero: error, 0xFFFF, no divide cycles
        frame(8'h03, 8'h05, 8'h00);
        check("div0_exec_busy", {15'h0, busy}, 16'h0001);
        cyc();
        check("div0_no_div", {15'h0, busy}, 16'h0000);
        check("div0_result_lo", {8'h00, result_lo}, 16'h00FF);
        pulse_stop();
        rd3(8'hFF, 8'hFF, 8'h41);

        // illegal opcode
        frame(8'h0F, 8'h03, 8'h04);
        wait_idle("illegal");
        pulse_stop();
        rd3(8'h00, 8'h00, 8'h41);

        // legal ADD clears err, then a short frame leaves it untouched
        frame(8'h00, 8'h01, 8'h01);
        wait_idle("add11");
        pulse_stop();
        pulse_start();
        send(8'h02);
        send(8'h05);
        pulse_stop();
        rd3(8'h00, 8'h02, 8'h01);

        // restart mid-frame with same-cycle opcode byte: ADD 4 + 5
        pulse_start();
        send(8'h02);
        send(8'h09);
        wr_start = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h00;
        cyc();
        wr_start = 1'b0;
        wr_valid = 1'b0;
        send(8'h04);
        send(8'h05);
        wait_idle("restart");
        pulse_stop();
        rd3(8'h00, 8'h09, 8'h01);

        // byte during DIV sets overrun; next wr_start clears it
        frame(8'h03, 8'hC8, 8'h07);
        cyc();
        send(8'h55);
        rd3(8'h00, 8'h09, 8'hA0);
        wait_idle("overrun");
        pulse_stop();
        rd3(8'h00, 8'h1C, 8'h21);
        pulse_start();
        pulse_stop();
        rd3(8'h00, 8'h1C, 8'h01);

        // reset in the middle of a divide
        frame(8'h03, 8'hC8, 8'h07);
        repeat (4) cyc();
        RST = 1'b1;
        #1;
        check("rst_mid_rd_data", {8'h00, rd_data}, 16'h0000);
        check("rst_mid_result_lo", {8'h00, result_lo}, 16'h0000);
        check("rst_mid_busy", {15'h0, busy}, 16'h0000);
        cyc();
        RST = 1'b0;
        cyc();
        rd3(8'h00, 8'h00, 8'h00);
        frame(8'h00, 8'h01, 8'h02);
        wait_idle("post_rst_add");
        pulse_stop();
        pulse_rd_start();
        rd(8'h00);
        rd(8'h03);
        rd(8'h01);
        rd(8'h00);

        repeat (3) cyc();
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
